// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - serial pattern transmitter, MSB first, repeated with idle gaps
module seq_gen_tx #(
  parameter int   PAT_W    = 3,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [CNT_W-1:0] rep_i,
  input  logic [CNT_W-1:0] gap_i,
  output logic             seq_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               seq_q, seq_d;
  logic               bit_valid_q, bit_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = IDLE_LVL;
    bit_valid_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          pat_d  = pat_i;
          rep_d  = rep_i;
          gap_d  = gap_i;
          busy_d = 1'b1;
          if (rep_i != '0) begin
            state_d     = SEND;
            sh_d        = pat_i;
            bit_cnt_d   = LAST_IDX;
            seq_d       = pat_i[PAT_W-1];
            bit_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      SEND: begin
        if (bit_cnt_q != '0) begin
          sh_d        = sh_q << 1;
          bit_cnt_d   = bit_cnt_q - IDX_W'(1);
          seq_d       = sh_d[PAT_W-1];
          bit_valid_d = 1'b1;
        end else begin
          // Last bit of this repetition is on the line now
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end else begin
            sh_d        = pat_q;
            bit_cnt_d   = LAST_IDX;
            seq_d       = pat_q[PAT_W-1];
            bit_valid_d = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d     = SEND;
          sh_d        = pat_q;
          bit_cnt_d   = LAST_IDX;
          seq_d       = pat_q[PAT_W-1];
          bit_valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= IDLE_LVL;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seq_o       = seq_q;
  assign bit_valid_o = bit_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - self-checking bench for seq_gen_tx with per-cycle expected-output queue
module tb_seq_gen_tx;
  localparam int PAT_W = 3;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start_i;
  logic [PAT_W-1:0] pat_i;
  logic [CNT_W-1:0] rep_i;
  logic [CNT_W-1:0] gap_i;
  logic             seq_o;
  logic             bit_valid_o;
  logic             busy_o;
  logic             done_o;

  seq_gen_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_LVL(1'b0)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start_i),
    .pat_i       (pat_i),
    .rep_i       (rep_i),
    .gap_i       (gap_i),
    .seq_o       (seq_o),
    .bit_valid_o (bit_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic seq;
    logic valid;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;
  logic last_busy = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
  endtask

  // Expected stream of one accepted transfer, one entry per cycle after the accept edge
  task automatic push_transfer(input logic [PAT_W-1:0] p, input int rep, input int gap);
    for (int r = 0; r < rep; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back('{p[b], 1'b1, 1'b1, 1'b0});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic cyc(input logic st, input logic rst);
    exp_t e;
    start_i = st;
    reset   = rst;
    if (rst) exp_q.delete();
    else if (st && !last_busy) push_transfer(pat_i, int'(rep_i), int'(gap_i));
    @(posedge clock);
    #1;
    cyc_no++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '{1'b0, 1'b0, 1'b0, 1'b0};
    last_busy = e.busy;
    chk("seq_o", seq_o, e.seq);
    chk("bit_valid_o", bit_valid_o, e.valid);
    chk("busy_o", busy_o, e.busy);
    chk("done_o", done_o, e.done);
    // Inputs wander after accept; the latched operands must stay in effect
    pat_i = PAT_W'($urandom);
    rep_i = CNT_W'($urandom);
    gap_i = CNT_W'($urandom);
  endtask

  task automatic launch(input logic [PAT_W-1:0] p, input int rep, input int gap);
    pat_i = p;
    rep_i = CNT_W'(rep);
    gap_i = CNT_W'(gap);
    cyc(1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    start_i = 1'b0;
    reset   = 1'b1;
    pat_i   = '0;
    rep_i   = '0;
    gap_i   = '0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    launch(3'b101, 1, 0);
    drain();

    launch(3'b101, 2, 2);
    drain();

    launch(3'b110, 3, 0);
    drain();

    launch(3'b011, 0, 5);
    drain();

    // Starts during SEND and during DONE are dropped; first IDLE cycle accepts
    launch(3'b101, 1, 0);
    cyc(1'b0, 1'b0);
    pat_i = 3'b111; rep_i = 8'd4; gap_i = 8'd1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    pat_i = 3'b111; rep_i = 8'd4; gap_i = 8'd1;
    cyc(1'b1, 1'b0);
    launch(3'b101, 1, 0);
    drain();

    // Reset mid-transfer aborts with no done pulse
    launch(3'b101, 2, 2);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    launch(3'b101, 2, 2);
    drain();

    launch(3'b100, 2, 1);
    drain();

    launch(3'b010, 2, 255);
    drain();

    launch(3'b111, 4, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
